serial_adder: RTL

- Parametrised multi-cycle adder/subtractor built around a registered full-adder slice.
- Adds two WIDTH-bit operands STEP bits per clock, with the carry held in a flip-flop between steps.
- Successor to the single-bit combinational full adder, for datapaths that trade latency for area.
- Used by the accumulator and ALU blocks; start/busy/done handshake.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands STEP bits per clock through a
// registered carry. Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

    generate
        if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_adder: STEP must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            last;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [STEP:0]    slice;

    // Handshake: start is sampled only while busy=0 (IDLE or DONE); busy stays high for the
    // NSTEPS RUN cycles, then done pulses for exactly one cycle with sum/c_out already valid.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Full-adder slice over the low STEP bits of the operand shift registers.
    assign slice = {1'b0, op_a_q[STEP-1:0]} + {1'b0, op_b_q[STEP-1:0]}
                 + {{STEP{1'b0}}, carry_q};

    // Result bits enter at the top so that after NSTEPS shifts the LSB slice sits at bit 0.
    assign part_next = (part_q >> STEP) | (WIDTH'(slice[STEP-1:0]) << (WIDTH - STEP));

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_cin;
    assign msb_cin = slice[STEP-1] ^ op_a_q[STEP-1] ^ op_b_q[STEP-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            part_q  <= '0;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            op_a_q  <= op_a_q >> STEP;
            op_b_q  <= op_b_q >> STEP;
            part_q  <= part_next;
            carry_q <= slice[STEP];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum   <= part_next;
                c_out <= slice[STEP];
`ifdef SERIAL_ADDER_OVF_EN
                ovf   <= slice[STEP] ^ msb_cin;
`endif
            end
        end
    end

endmodule
